// File: rtl/subservient_sram_arb.sv
// subservient_sram_arb
// Shares a byte-wide SRAM between the subservient core and a 32-bit Wishbone
// host. The SRAM has one write port and one read port. The core always has
// priority on each port, and its 1-cycle SRAM timing is never stalled. A host
// word access is split into four byte slots. Each slot runs in a cycle where
// the core leaves the matching port idle.
//
// Ports
//   i_clk, i_rst_n              clock, synchronous active-low reset
//   i_cpu_w*/i_cpu_r*           core write/read strobes, addresses and data
//   o_cpu_rdata                 core read data (SRAM data passed through)
//   i_wb_*                      Wishbone host request
//   o_wb_rdt, o_wb_ack          host read data and 1-cycle ack
//   o_sram_*                    SRAM write/read port controls
//   i_sram_rdata                SRAM read data, valid the cycle after ren
module subservient_sram_arb #(
  parameter int memsize = 512,
  parameter int aw      = $clog2(memsize)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [aw-1:0] i_cpu_waddr,
  input  logic [7:0]    i_cpu_wdata,
  input  logic          i_cpu_wen,
  input  logic [aw-1:0] i_cpu_raddr,
  input  logic          i_cpu_ren,
  output logic [7:0]    o_cpu_rdata,
  input  logic [31:0]   i_wb_adr,
  input  logic [31:0]   i_wb_dat,
  input  logic [3:0]    i_wb_sel,
  input  logic          i_wb_we,
  input  logic          i_wb_stb,
  input  logic          i_wb_cyc,
  output logic [31:0]   o_wb_rdt,
  output logic          o_wb_ack,
  output logic [aw-1:0] o_sram_waddr,
  output logic [7:0]    o_sram_wdata,
  output logic          o_sram_wen,
  output logic [aw-1:0] o_sram_raddr,
  output logic          o_sram_ren,
  input  logic [7:0]    i_sram_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_ACK} state_t;

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_lane, w_lane_nxt;
  logic [1:0]  r_rd_lane, w_rd_lane_nxt;
  logic        r_rd_pend, w_rd_pend_nxt;
  logic        r_rd_last, w_rd_last_nxt;   // all four read slots issued
  logic [31:0] r_rdt;

  logic [aw-1:0] w_slot_addr;
  logic          w_host_wslot;
  logic          w_host_rslot;
  logic          w_capture;

  assign w_slot_addr = {i_wb_adr[aw-1:2], r_lane};

  // Host slots are suppressed as soon as cyc drops so an aborted transfer
  // touches no further bytes, and also while reset is asserted.
  assign w_host_wslot = i_rst_n & i_wb_cyc & (r_state == S_WR) & ~i_cpu_wen;
  assign w_host_rslot = i_rst_n & i_wb_cyc & (r_state == S_RD) & ~r_rd_last & ~i_cpu_ren;
  // A pending byte is discarded on abort.
  assign w_capture    = r_rd_pend & i_wb_cyc & (r_state == S_RD);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_lane    <= 2'd0;
      r_rd_lane <= 2'd0;
      r_rd_pend <= 1'b0;
      r_rd_last <= 1'b0;
      r_rdt     <= 32'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_lane    <= w_lane_nxt;
      r_rd_lane <= w_rd_lane_nxt;
      r_rd_pend <= w_rd_pend_nxt;
      r_rd_last <= w_rd_last_nxt;
      if (w_capture) r_rdt[8*r_rd_lane +: 8] <= i_sram_rdata;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_lane_nxt    = r_lane;
    w_rd_lane_nxt = r_rd_lane;
    w_rd_pend_nxt = 1'b0;
    w_rd_last_nxt = r_rd_last;
    case (r_state)
      S_IDLE: begin
        w_rd_last_nxt = 1'b0;
        if (i_wb_cyc && i_wb_stb) begin
          w_state_nxt = i_wb_we ? S_WR : S_RD;
          w_lane_nxt  = 2'd0;
        end
      end
      S_WR: begin
        if (!i_wb_cyc) begin
          w_state_nxt = S_IDLE;
        end else if (w_host_wslot) begin
          w_lane_nxt = r_lane + 2'd1;
          if (r_lane == 2'd3) w_state_nxt = S_ACK;
        end
      end
      S_RD: begin
        if (!i_wb_cyc) begin
          w_state_nxt = S_IDLE;
        end else if (w_host_rslot) begin
          w_rd_pend_nxt = 1'b1;
          w_rd_lane_nxt = r_lane;
          w_lane_nxt    = r_lane + 2'd1;
          if (r_lane == 2'd3) w_rd_last_nxt = 1'b1;
        end else if (r_rd_last && r_rd_pend) begin
          // The last byte is captured on this edge.
          w_state_nxt = S_ACK;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    o_sram_wen   = i_cpu_wen | (w_host_wslot & i_wb_sel[r_lane]);
    o_sram_waddr = i_cpu_wen ? i_cpu_waddr : w_slot_addr;
    o_sram_wdata = i_cpu_wen ? i_cpu_wdata : i_wb_dat[8*r_lane +: 8];
    o_sram_ren   = i_cpu_ren | w_host_rslot;
    o_sram_raddr = i_cpu_ren ? i_cpu_raddr : w_slot_addr;
    o_cpu_rdata  = i_sram_rdata;
    o_wb_ack     = (r_state == S_ACK);
    o_wb_rdt     = r_rdt;
  end

endmodule

// File: tb/tb_subservient_sram_arb.sv
module tb_subservient_sram_arb;
  localparam int MS = 512;
  localparam int AW = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [AW-1:0] cpu_waddr, cpu_raddr;
  logic [7:0]    cpu_wdata, cpu_rdata;
  logic          cpu_wen, cpu_ren;
  logic [31:0]   wb_adr, wb_dat, wb_rdt;
  logic [3:0]    wb_sel;
  logic          wb_we, wb_stb, wb_cyc, wb_ack;
  logic [AW-1:0] s_waddr, s_raddr;
  logic [7:0]    s_wdata, s_rdata;
  logic          s_wen, s_ren;

  subservient_sram_arb #(.memsize(MS)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cpu_waddr(cpu_waddr), .i_cpu_wdata(cpu_wdata), .i_cpu_wen(cpu_wen),
    .i_cpu_raddr(cpu_raddr), .i_cpu_ren(cpu_ren), .o_cpu_rdata(cpu_rdata),
    .i_wb_adr(wb_adr), .i_wb_dat(wb_dat), .i_wb_sel(wb_sel), .i_wb_we(wb_we),
    .i_wb_stb(wb_stb), .i_wb_cyc(wb_cyc), .o_wb_rdt(wb_rdt), .o_wb_ack(wb_ack),
    .o_sram_waddr(s_waddr), .o_sram_wdata(s_wdata), .o_sram_wen(s_wen),
    .o_sram_raddr(s_raddr), .o_sram_ren(s_ren), .i_sram_rdata(s_rdata)
  );

  // SRAM attached to the DUT: read-before-write, data one cycle after ren.
  bit [7:0] sram [MS];
  always @(posedge clk) begin
    if (s_wen === 1'b1) sram[s_waddr] <= s_wdata;
    if (s_ren === 1'b1) s_rdata <= sram[s_raddr];
  end

  int cycnt = 0;
  always @(posedge clk) cycnt <= cycnt + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Core stimulus: random, or scripted windows given in cycle labels.
  bit core_rnd = 1'b0;
  int pw_lo = 1, pw_hi = 0, pr_lo = 1, pr_hi = 0;
  initial begin
    int lbl;
    cpu_wen = 1'b0; cpu_ren = 1'b0; cpu_waddr = '0; cpu_raddr = '0; cpu_wdata = '0;
    forever begin
      @(negedge clk); #1;
      lbl = cycnt + 1;
      if (core_rnd) begin
        cpu_wen   = ($urandom_range(0, 2) == 0);
        cpu_waddr = AW'($urandom_range(0, MS-1));
        cpu_wdata = 8'($urandom);
        cpu_ren   = ($urandom_range(0, 2) == 0);
        cpu_raddr = AW'($urandom_range(0, MS-1));
      end else begin
        cpu_wen   = (lbl >= pw_lo && lbl <= pw_hi);
        cpu_waddr = AW'(9'h100 + 9'(lbl % 64));
        cpu_wdata = 8'(lbl);
        cpu_ren   = (lbl >= pr_lo && lbl <= pr_hi);
        cpu_raddr = AW'(9'h010);
      end
    end
  end

  // Reference model: transaction-level view of the shared SRAM.
  bit [7:0]    ref_mem [MS];
  bit          m_busy = 0, m_we = 0, m_ack = 0;
  logic [31:0] m_rdt = '0;
  bit [31:0]   m_adr, m_dat;
  bit [3:0]    m_sel;
  int          m_done = 0, m_pend = -1;
  bit [7:0]    m_pend_val;
  bit          core_pend = 0;
  bit [7:0]    core_val;
  bit          chk_en = 0;

  initial begin
    int base, slot, old_pend, old_done;
    bit hw, hr, exp_wen, exp_ren;
    forever begin
      @(negedge clk); #2;
      base = int'(m_adr & (MS - 1)) & ~3;
      slot = base + m_done;
      hw = rst_n && m_busy && m_we  && wb_cyc && m_done < 4 && !cpu_wen;
      hr = rst_n && m_busy && !m_we && wb_cyc && m_done < 4 && !cpu_ren;
      exp_wen = cpu_wen || (hw && m_sel[m_done]);
      exp_ren = cpu_ren || hr;
      if (chk_en) begin
        chk("sram_wen", 32'(s_wen), 32'(exp_wen));
        if (exp_wen) begin
          chk("sram_waddr", 32'(s_waddr), cpu_wen ? 32'(cpu_waddr) : 32'(slot));
          chk("sram_wdata", 32'(s_wdata), cpu_wen ? 32'(cpu_wdata) : 32'(m_dat[8*m_done +: 8]));
        end
        chk("sram_ren", 32'(s_ren), 32'(exp_ren));
        if (exp_ren) chk("sram_raddr", 32'(s_raddr), cpu_ren ? 32'(cpu_raddr) : 32'(slot));
        chk("wb_ack", 32'(wb_ack), 32'(m_ack));
        chk("wb_rdt", wb_rdt, m_rdt);
        if (core_pend) chk("cpu_rdata", 32'(cpu_rdata), 32'(core_val));
      end
      // values seen by reads issued this cycle (before this cycle's write)
      core_pend = cpu_ren;
      if (cpu_ren) core_val = ref_mem[cpu_raddr];
      old_pend = m_pend;
      old_done = m_done;
      if (cpu_wen) ref_mem[cpu_waddr] = cpu_wdata;
      else if (hw && m_sel[m_done]) ref_mem[slot] = m_dat[8*m_done +: 8];
      if (!rst_n) begin
        m_busy = 0; m_ack = 0; m_rdt = '0; m_pend = -1; m_done = 0;
      end else if (m_ack) begin
        m_ack = 0;
      end else if (!m_busy) begin
        if (wb_cyc && wb_stb) begin
          m_busy = 1; m_we = wb_we; m_adr = wb_adr; m_dat = wb_dat; m_sel = wb_sel;
          m_done = 0; m_pend = -1;
        end
      end else if (!wb_cyc) begin
        m_busy = 0; m_pend = -1;
      end else begin
        if (old_pend >= 0) m_rdt[8*old_pend +: 8] = m_pend_val;
        m_pend = -1;
        if (hr) begin
          m_pend = m_done;
          m_pend_val = ref_mem[slot];
        end
        if (hw || hr) m_done++;
        if (m_we && m_done == 4) begin m_busy = 0; m_ack = 1; end
        if (!m_we && old_done == 4 && old_pend >= 0) begin m_busy = 0; m_ack = 1; end
      end
    end
  end

  // Host transfer; rlo/rhi and wlo/whi are core strobe windows relative to
  // the acceptance edge k; abort_after >= 0 drops cyc in cycle k+1+abort_after.
  task automatic host_xfer(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input int abort_after,
                           input int rlo, input int rhi, input int wlo, input int whi,
                           output int lat);
    int k;
    bit got;
    @(negedge clk);
    k = cycnt + 1;
    pr_lo = k + rlo; pr_hi = k + rhi; pw_lo = k + wlo; pw_hi = k + whi;
    wb_we = we; wb_adr = adr; wb_dat = dat; wb_sel = sel; wb_cyc = 1'b1; wb_stb = 1'b1;
    @(posedge clk); #1;
    k = cycnt;
    got = 0;
    lat = -1;
    for (int i = 0; i < 200; i++) begin
      if (wb_ack === 1'b1) begin
        got = 1;
        lat = cycnt - k + 1;
        break;
      end
      if (abort_after >= 0 && i == abort_after) begin
        @(negedge clk);
        wb_cyc = 1'b0; wb_stb = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    if (!got && abort_after < 0) begin
      checks++; errors++;
      $display("FAIL ack_timeout actual=no_ack expected=ack adr=%h", adr);
    end
    @(negedge clk);
    wb_cyc = 1'b0; wb_stb = 1'b0;
  endtask

  initial begin
    int lat, nmis;
    rst_n = 1'b0;
    wb_adr = '0; wb_dat = '0; wb_sel = 4'hF; wb_we = 1'b1; wb_cyc = 1'b1; wb_stb = 1'b1;
    core_rnd = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", 32'(wb_ack), 32'd0);
    chk("rst_rdt", wb_rdt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; wb_cyc = 1'b0; wb_stb = 1'b0; core_rnd = 1'b0;
    repeat (2) @(negedge clk);

    host_xfer(1, 32'h10, 32'hDEADBEEF, 4'hF, -1, 1, 0, 1, 0, lat);
    chk("wr_full_lat", lat, 5);
    chk("wr_full_mem", {sram[19], sram[18], sram[17], sram[16]}, 32'hDEADBEEF);
    chk("model_mem", {ref_mem[19], ref_mem[18], ref_mem[17], ref_mem[16]}, 32'hDEADBEEF);

    host_xfer(1, 32'h10, 32'h0, 4'hF, -1, 1, 0, 1, 0, lat);
    host_xfer(1, 32'h10, 32'hDEADBEEF, 4'b0101, -1, 1, 0, 1, 0, lat);
    chk("wr_sel_lat", lat, 5);
    chk("wr_sel_mem", {sram[19], sram[18], sram[17], sram[16]}, 32'h00AD00EF);

    host_xfer(1, 32'h10, 32'hDEADBEEF, 4'hF, -1, 1, 0, 1, 0, lat);
    host_xfer(0, 32'h10, 32'h0, 4'h0, -1, 2, 3, 1, 0, lat);
    chk("rd_contend_lat", lat, 8);
    chk("rd_contend_rdt", wb_rdt, 32'hDEADBEEF);
    chk("model_rdt", m_rdt, 32'hDEADBEEF);

    host_xfer(1, 32'h20, 32'hCAFEF00D, 4'hF, -1, 1, 0, 1, 10, lat);
    chk("wr_contend_lat", lat, 15);
    chk("wr_contend_mem", {sram[35], sram[34], sram[33], sram[32]}, 32'hCAFEF00D);

    host_xfer(1, 32'h20, 32'h12345678, 4'hF, 2, 1, 0, 1, 0, lat);
    chk("abort_noack", lat, -1);
    chk("abort_mem", {sram[35], sram[34], sram[33], sram[32]}, 32'hCAFE5678);
    host_xfer(0, 32'h20, 32'h0, 4'hF, -1, 1, 0, 1, 0, lat);
    chk("rd_after_abort_lat", lat, 6);
    chk("rd_after_abort_rdt", wb_rdt, 32'hCAFE5678);

    host_xfer(1, 32'h00000204, 32'hA5A50F0F, 4'hF, -1, 1, 0, 1, 0, lat);
    chk("wrap_mem", {sram[7], sram[6], sram[5], sram[4]}, 32'hA5A50F0F);

    core_rnd = 1'b1;
    for (int t = 0; t < 80; t++) begin
      int ab;
      ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 6)) : -1;
      host_xfer(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom), ab,
                1, 0, 1, 0, lat);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    core_rnd = 1'b0;
    repeat (4) @(negedge clk);
    nmis = 0;
    for (int a = 0; a < MS; a++) if (sram[a] != ref_mem[a]) nmis++;
    chk("mem_image_mismatches", nmis, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
